// File: rtl/xor_parity_engine.sv
// xor_parity_engine: streaming XOR/XNOR/accumulate/parity unit
// with a globally stalled valid/ready pipeline of STAGES registers.
module xor_parity_engine #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity
);

  localparam logic [1:0] M_XOR  = 2'b00;
  localparam logic [1:0] M_XNOR = 2'b01;
  localparam logic [1:0] M_ACC  = 2'b10;
  localparam logic [1:0] M_PAR  = 2'b11;

  // each stage word is {parity, result}
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH:0]    dat_q [STAGES];
  logic [WIDTH:0]    dat_d [STAGES];
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  acc_base;
  logic [WIDTH-1:0]  res;
  logic              stall;
  logic              accept;

  assign stall     = vld_q[STAGES-1] && !out_ready;
  assign in_ready  = !rst && !stall;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign y         = dat_q[STAGES-1][WIDTH-1:0];
  assign parity    = dat_q[STAGES-1][WIDTH];

  // stage-1 result and accumulator update; clear wins over old acc
  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    res      = '0;
    unique case (mode)
      M_XOR:  res = a ^ b;
      M_XNOR: res = ~(a ^ b);
      M_ACC:  res = acc_base ^ a;
      M_PAR:  res[0] = ^(a ^ b);
    endcase
    acc_d = acc_base;
    if (accept && mode == M_ACC) acc_d = res;
  end

  // pipe advance; data only moves with valid so y holds through bubbles
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (!stall) begin
      vld_d[0] = accept;
      if (accept) dat_d[0] = {^res, res};
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end
  end

  // state registers; reset drops every beat in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= dat_d[i];
    end
  end

endmodule
